// File: rtl/udp_rate_gen_mc_if.sv
// Send handshake between the rate generator and the UDP packet builder.
// The generator offers a channel index and holds it until the builder accepts it.
interface udp_rate_gen_mc_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic            send_valid;
    logic [CH_W-1:0] send_ch;
    logic            send_ready;

    modport master (
        output send_valid,
        output send_ch,
        input  send_ready
    );

    modport slave (
        input  send_valid,
        input  send_ch,
        output send_ready
    );
endinterface

// File: rtl/udp_rate_gen_mc.sv
// Multi-channel UDP test-traffic rate generator: per-channel phase accumulators
// feed saturating credit counters, which are granted round-robin onto one send port.
module udp_rate_gen_mc #(
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 32,
    parameter int PEND_W = 4,
    parameter int BL_W   = 16,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*ACC_W-1:0] speed,
    input  logic                    burst_mode,
    input  logic                    burst_start,
    input  logic [BL_W-1:0]         burst_len,
    udp_rate_gen_mc_if.master       snd,
    output logic [NUM_CH-1:0]       drop,
    output logic                    burst_done,
    output logic [CNT_W-1:0]        sent_cnt
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PEND_W-1:0] CRED_MAX = '1;
    localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    logic [ACC_W-1:0]  acc_q  [NUM_CH];
    logic [ACC_W-1:0]  acc_d  [NUM_CH];
    logic [PEND_W-1:0] cred_q [NUM_CH];
    logic [PEND_W-1:0] cred_d [NUM_CH];
    logic [BL_W-1:0]   rem_q  [NUM_CH];
    logic [BL_W-1:0]   rem_d  [NUM_CH];
    logic [NUM_CH-1:0] drop_q, drop_d;
    logic [NUM_CH-1:0] tick, counted, grant;
    logic [NUM_CH-1:0] has_q, has_d, rem_nz;
    logic [CH_W-1:0]   rr_q, rr_d, ch_q, ch_d;
    logic [CH_W:0]     nxt_wide;
    logic [CH_W-1:0]   nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_t            state_q, state_d;
    logic              hs;

    // First requesting channel at or after start, wrapping around.
    function automatic logic [CH_W-1:0] rr_pick(
        input logic [NUM_CH-1:0] req,
        input logic [CH_W-1:0]   start
    );
        logic [2*NUM_CH-1:0] dbl;
        logic [CH_W:0]       idx;
        logic [CH_W-1:0]     res;
        dbl = {req, req} >> start;
        idx = '0;
        res = start;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                idx = {1'b0, start} + (CH_W+1)'(k);
                if (idx >= NCH) idx = idx - NCH;
                res = idx[CH_W-1:0];
            end
        end
        return res;
    endfunction

    assign hs = (state_q == S_OFFER) && snd.send_ready;

    assign nxt_wide = ({1'b0, ch_q} + (CH_W+1)'(1) >= NCH) ?
                      '0 : {1'b0, ch_q} + (CH_W+1)'(1);
    assign nxt = nxt_wide[CH_W-1:0];

    // Per-channel accumulator, burst gating and credit counting.
    always_comb begin
        logic [ACC_W:0] sum;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, acc_q[i]} + {1'b0, speed[i*ACC_W +: ACC_W]};
            acc_d[i] = acc_q[i];
            tick[i]  = 1'b0;
            if (en[i]) begin
                acc_d[i] = sum[ACC_W-1:0];
                tick[i]  = sum[ACC_W];
            end
            rem_d[i] = burst_start ? burst_len : rem_q[i];
            counted[i] = tick[i] & (~burst_mode | (rem_d[i] != '0));
            if (counted[i] && burst_mode) rem_d[i] = rem_d[i] - BL_W'(1);
            grant[i]  = hs && (ch_q == CH_W'(i));
            cred_d[i] = cred_q[i];
            drop_d[i] = drop_q[i];
            if (counted[i] && !grant[i]) begin
                if (cred_q[i] == CRED_MAX) drop_d[i] = 1'b1;
                else cred_d[i] = cred_q[i] + PEND_W'(1);
            end else if (grant[i] && !counted[i]) begin
                cred_d[i] = cred_q[i] - PEND_W'(1);
            end
            has_q[i]  = (cred_q[i] != '0);
            has_d[i]  = (cred_d[i] != '0);
            rem_nz[i] = (rem_q[i] != '0);
        end
    end

    // Arbiter: pick a pending channel, hold the offer until it is accepted.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (|has_q) begin
                    ch_d    = rr_pick(has_q, rr_q);
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (snd.send_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    rr_d  = nxt;
                    if (|has_d) ch_d = rr_pick(has_d, nxt);
                    else state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset clears every channel and the arbiter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]  <= '0;
                cred_q[i] <= '0;
                rem_q[i]  <= '0;
            end
            drop_q  <= '0;
            rr_q    <= '0;
            ch_q    <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]  <= acc_d[i];
                cred_q[i] <= cred_d[i];
                rem_q[i]  <= rem_d[i];
            end
            drop_q  <= drop_d;
            rr_q    <= rr_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign snd.send_valid = (state_q == S_OFFER);
    assign snd.send_ch    = ch_q;
    assign drop           = drop_q;
    assign sent_cnt       = cnt_q;
    assign burst_done     = ~burst_mode |
                            (~|rem_nz & ~|has_q & (state_q == S_IDLE));
endmodule

// File: tb/tb_udp_rate_gen_mc.sv
// Self-checking bench for udp_rate_gen_mc.
// A transaction-level model tracks phase, credits and round-robin order.
module tb_udp_rate_gen_mc;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   en;
    logic [127:0] speed;
    logic         burst_mode, burst_start;
    logic [15:0]  burst_len;
    logic [3:0]   drop;
    logic         burst_done;
    logic [31:0]  sent_cnt;

    udp_rate_gen_mc_if #(.NUM_CH(N)) sif();

    udp_rate_gen_mc #(.NUM_CH(N)) dut (
        .clk(clk), .rst(rst), .en(en), .speed(speed),
        .burst_mode(burst_mode), .burst_start(burst_start),
        .burst_len(burst_len), .snd(sif.master), .drop(drop),
        .burst_done(burst_done), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_acc [N];
    int          m_cred [N];
    int          m_rem [N];
    logic [3:0]  m_drop;
    logic        m_valid;
    int          m_ch, m_rr;
    logic [31:0] m_sent;

    function automatic int first_pend(input int c[N], input int start);
        for (int k = 0; k < N; k++)
            if (c[(start + k) % N] > 0) return (start + k) % N;
        return -1;
    endfunction

    function automatic bit m_done();
        bit z = 1;
        for (int i = 0; i < N; i++)
            if (m_rem[i] != 0 || m_cred[i] != 0) z = 0;
        return !burst_mode || (z && !m_valid);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N; i++) begin
            m_acc[i] = 0; m_cred[i] = 0; m_rem[i] = 0;
        end
        m_drop = 0; m_valid = 0; m_ch = 0; m_rr = 0; m_sent = 0;
    endtask

    // One clock edge: advance the model with the inputs present at the edge.
    task automatic step();
        bit hs, tk, cnt;
        int g, c, p;
        int old_c [N];
        logic [32:0] s;
        @(posedge clk);
        hs = m_valid && sif.send_ready;
        g = m_ch;
        old_c = m_cred;
        for (int i = 0; i < N; i++) begin
            tk = 0;
            if (en[i]) begin
                s = {1'b0, m_acc[i]} + {1'b0, speed[i*32 +: 32]};
                m_acc[i] = s[31:0];
                tk = s[32];
            end
            if (burst_start) m_rem[i] = int'(burst_len);
            cnt = tk && (!burst_mode || m_rem[i] > 0);
            if (cnt && burst_mode) m_rem[i]--;
            c = old_c[i] + int'(cnt) - ((hs && g == i) ? 1 : 0);
            if (c > 15) begin c = 15; m_drop[i] = 1'b1; end
            m_cred[i] = c;
        end
        if (hs) begin
            m_sent++;
            m_rr = (g + 1) % N;
            p = first_pend(m_cred, m_rr);
            m_valid = (p >= 0);
            if (p >= 0) m_ch = p;
        end else if (!m_valid) begin
            p = first_pend(old_c, m_rr);
            if (p >= 0) begin m_valid = 1; m_ch = p; end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; en = 0; speed = 0; burst_mode = 0; burst_start = 0;
        burst_len = 0; sif.send_ready = 0;
        m_clear();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        burst_mode = 1;
        #1;
        n_chk++; if (sif.send_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid got %b exp 0", sif.send_valid); end
        n_chk++; if (sif.send_ch !== 2'd0) begin n_fail++;
            $display("FAIL reset_ch got %0d exp 0", sif.send_ch); end
        n_chk++; if (drop !== 4'h0) begin n_fail++;
            $display("FAIL reset_drop got %h exp 0", drop); end
        n_chk++; if (burst_done !== 1'b1) begin n_fail++;
            $display("FAIL reset_done got %b exp 1", burst_done); end
        n_chk++; if (sent_cnt !== 32'd0) begin n_fail++;
            $display("FAIL reset_cnt got %0d exp 0", sent_cnt); end
    endtask

    task automatic test_single_rate();
        int n = 0;
        do_reset();
        speed[31:0] = 32'h4000_0000; en = 4'b0001; sif.send_ready = 1;
        for (int k = 0; k < 20 && !sif.send_valid; k++) begin
            step(); n++;
        end
        n_chk++; if (n !== 5) begin n_fail++;
            $display("FAIL rate_first got %0d exp 5", n); end
        for (int k = 0; k < 39; k++) begin
            step();
            n_chk++; if (sif.send_valid !== m_valid) begin n_fail++;
                $display("FAIL rate_valid got %b exp %b", sif.send_valid, m_valid); end
        end
        n_chk++; if (sent_cnt !== 32'd10) begin n_fail++;
            $display("FAIL rate_cnt got %0d exp 10", sent_cnt); end
    endtask

    task automatic test_alternate();
        int cnt0 = 0, cnt1 = 0, last = -1, c20 = 0;
        bit hs; int ch;
        do_reset();
        speed[31:0] = 32'h8000_0000; speed[63:32] = 32'h8000_0000;
        en = 4'b0011; sif.send_ready = 1;
        for (int k = 1; k <= 30; k++) begin
            hs = sif.send_valid && sif.send_ready;
            ch = int'(sif.send_ch);
            step();
            if (hs) begin
                if (ch == 0) cnt0++; else cnt1++;
                n_chk++; if (ch == last) begin n_fail++;
                    $display("FAIL alt_order got ch %0d twice", ch); end
                last = ch;
            end
            if (k == 20) c20 = int'(sent_cnt);
            n_chk++; if (sif.send_valid !== m_valid ||
                         (m_valid && int'(sif.send_ch) != m_ch)) begin n_fail++;
                $display("FAIL alt_offer got %b/%0d exp %b/%0d",
                         sif.send_valid, sif.send_ch, m_valid, m_ch); end
        end
        n_chk++; if (cnt0 < 13 || cnt1 < 13) begin n_fail++;
            $display("FAIL alt_starve got %0d/%0d exp >=13 each", cnt0, cnt1); end
        n_chk++; if (int'(sent_cnt) - c20 != 10) begin n_fail++;
            $display("FAIL alt_rate got %0d exp 10", int'(sent_cnt) - c20); end
    endtask

    task automatic test_saturate();
        bit seen = 0; int n = 0;
        do_reset();
        speed[31:0] = 32'hFFFF_FFFF; en = 4'b0001;
        for (int k = 0; k < 40; k++) begin
            step();
            if (seen) begin
                n_chk++; if (sif.send_valid !== 1'b1 || sif.send_ch !== 2'd0) begin
                    n_fail++;
                    $display("FAIL sat_stable got %b/%0d exp 1/0",
                             sif.send_valid, sif.send_ch); end
            end
            if (sif.send_valid) seen = 1;
        end
        n_chk++; if (drop !== 4'b0001) begin n_fail++;
            $display("FAIL sat_drop got %b exp 0001", drop); end
        en = 0; sif.send_ready = 1;
        for (int k = 0; k < 25; k++) begin
            if (sif.send_valid) n++;
            step();
        end
        n_chk++; if (n != 15) begin n_fail++;
            $display("FAIL sat_credit got %0d exp 15", n); end
    endtask

    task automatic test_burst();
        int per [N]; int tot = 0; bit hs; int ch;
        do_reset();
        per = '{default: 0};
        burst_mode = 1; burst_len = 16'd3; en = 4'hF;
        for (int i = 0; i < N; i++) speed[i*32 +: 32] = $urandom | 32'h1000_0000;
        repeat (20) step();
        n_chk++; if (sif.send_valid !== 1'b0 || burst_done !== 1'b1) begin n_fail++;
            $display("FAIL burst_idle got %b/%b exp 0/1", sif.send_valid, burst_done); end
        burst_start = 1;
        for (int k = 0; k < 200; k++) begin
            hs = sif.send_valid && sif.send_ready;
            ch = int'(sif.send_ch);
            step();
            burst_start = 0;
            if (hs) begin per[ch]++; tot++; end
            n_chk++; if (sif.send_valid !== m_valid || burst_done !== m_done()) begin
                n_fail++;
                $display("FAIL burst_track got %b/%b exp %b/%b",
                         sif.send_valid, burst_done, m_valid, m_done()); end
            sif.send_ready = ($urandom_range(0, 3) != 0);
        end
        n_chk++; if (tot != 12) begin n_fail++;
            $display("FAIL burst_total got %0d exp 12", tot); end
        for (int i = 0; i < N; i++) begin
            n_chk++; if (per[i] != 3) begin n_fail++;
                $display("FAIL burst_ch%0d got %0d exp 3", i, per[i]); end
        end
        n_chk++; if (burst_done !== 1'b1) begin n_fail++;
            $display("FAIL burst_done got %b exp 1", burst_done); end
        burst_len = 0; burst_start = 1;
        for (int k = 0; k < 30; k++) begin
            step();
            burst_start = 0;
            n_chk++; if (sif.send_valid !== 1'b0 || burst_done !== 1'b1) begin
                n_fail++;
                $display("FAIL burst_zero got %b/%b exp 0/1",
                         sif.send_valid, burst_done); end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        speed[31:0] = 32'hFFFF_FFFF; en = 4'b0001; sif.send_ready = 1;
        repeat (6) step();
        sif.send_ready = 0;
        repeat (6) step();
        n_chk++; if (sif.send_valid !== 1'b1 || sent_cnt == 32'd0) begin n_fail++;
            $display("FAIL mid_pre got %b/%0d exp 1/>0", sif.send_valid, sent_cnt); end
        rst = 1;
        m_clear();
        #1;
        n_chk++; if (sif.send_valid !== 1'b0 || sent_cnt !== 32'd0) begin n_fail++;
            $display("FAIL mid_async got %b/%0d exp 0/0", sif.send_valid, sent_cnt); end
        en = 0; sif.send_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_chk++; if (sif.send_valid !== 1'b0) begin n_fail++;
                $display("FAIL mid_residue got %b exp 0", sif.send_valid); end
        end
        speed[31:0] = 32'h4000_0000; en = 4'b0001;
        for (int k = 0; k < 20 && !sif.send_valid; k++) begin
            step(); n++;
        end
        n_chk++; if (n != 5) begin n_fail++;
            $display("FAIL mid_restart got %0d exp 5", n); end
    endtask

    task automatic test_en_gap();
        int n = 0;
        do_reset();
        speed[31:0] = 32'h4000_0000; en = 4'b0001; sif.send_ready = 1;
        repeat (6) step();
        en = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_chk++; if (sif.send_valid !== 1'b0) begin n_fail++;
                $display("FAIL gap_valid got %b exp 0", sif.send_valid); end
        end
        en = 4'b0001;
        for (int k = 0; k < 20 && !sif.send_valid; k++) begin
            step(); n++;
        end
        n_chk++; if (n != 3) begin n_fail++;
            $display("FAIL gap_phase got %0d exp 3", n); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < N; i++) speed[i*32 +: 32] = $urandom >> $urandom_range(0, 4);
        en = 4'($urandom);
        for (int k = 0; k < 600; k++) begin
            step();
            burst_start = 0;
            n_chk++; if (sif.send_valid !== m_valid ||
                         (m_valid && int'(sif.send_ch) != m_ch)) begin n_fail++;
                $display("FAIL rnd_offer t=%0t got %b/%0d exp %b/%0d", $time,
                         sif.send_valid, sif.send_ch, m_valid, m_ch); end
            n_chk++; if (sent_cnt !== m_sent || drop !== m_drop) begin n_fail++;
                $display("FAIL rnd_cnt t=%0t got %0d/%b exp %0d/%b", $time,
                         sent_cnt, drop, m_sent, m_drop); end
            n_chk++; if (burst_done !== m_done()) begin n_fail++;
                $display("FAIL rnd_done t=%0t got %b exp %b", $time,
                         burst_done, m_done()); end
            sif.send_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 31) == 0) begin
                en = 4'($urandom);
                for (int i = 0; i < N; i++)
                    speed[i*32 +: 32] = $urandom >> $urandom_range(0, 4);
            end
            if ($urandom_range(0, 63) == 0) burst_mode = ~burst_mode;
            if ($urandom_range(0, 39) == 0) begin
                burst_start = 1;
                burst_len = 16'($urandom_range(0, 5));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_rate();
        test_alternate();
        test_saturate();
        test_burst();
        test_reset_mid();
        test_en_gap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
